oam_responder: RTL
==================

# oam_responder

Serves the sprite engine's OAM read port: it accepts single-cycle `oam_read` requests from the OAM scanner and answers each with a one-cycle `oam_avail` strobe carrying the addressed `sprite_conf_t`. OAM is double-buffered. The scanner always reads the front bank, while the CPU-side interface writes the back bank. Banks swap only at a frame boundary and never while a read is outstanding. The block sits between the PPU's CPU/HPS write path and `oam_scanner` inside the sprite engine.

## Interface
- `MAX_SPRITES`, default `` `MAX_SPRITES `` (from `sprite_defines.vh`): entries per bank; valid addresses are 0..MAX_SPRITES-1.
- `clock`  in  1  system clock.
- `reset_l`  in  1  asynchronous, active-low reset.
- `clear`  in  1  line restart, the same signal the scanner sees; aborts any outstanding read.
- `oam_addr`  in  7  read address from the scanner; sampled only in the cycle `oam_read`=1.
- `oam_read`  in  1  single-cycle read request.
- `oam_avail`  out  1  one-cycle response strobe.
- `oam_data`  out  sprite_conf_t  response data; valid when `oam_avail`=1, held until the next response.
- `wr_en`  in  1  CPU write strobe to the back bank.
- `wr_addr`  in  7  CPU write address.
- `wr_data`  in  sprite_conf_t  CPU write data.
- `swap_req`  in  1  frame-boundary pulse requesting a bank swap.
- `front_bank`  out  1  index of the bank currently read by the scanner.

## Operation
- Storage: two synchronous-read RAMs of MAX_SPRITES x `$bits(sprite_conf_t)`. Contents are not reset.
- Writes:
  - `wr_en`=1 with `wr_addr` < MAX_SPRITES writes bank `~front_bank` in the same cycle.
  - Writes to out-of-range addresses are dropped.
  - Writes never touch the front bank.
- Read FSM, states IDLE, RAM_WAIT, RESP:
  - IDLE: on `oam_read`=1 and `clear`=0, latch `oam_addr` and the current `front_bank` into the request register, issue the RAM read, go to RAM_WAIT. Latching is mandatory: the scanner increments its address in the same cycle.
  - RAM_WAIT: RAM output becomes valid; register it into `oam_data`; go to RESP.
  - RESP: `oam_avail`=1 for exactly this cycle; go to IDLE.
  - `clear`=1 in any state: go to IDLE next cycle. A pending response is discarded, so `oam_avail` is 0 in the cycle after `clear`, and `oam_data` is not updated.
  - `oam_read` in RAM_WAIT or RESP is ignored; no second response is generated.
  - `oam_read` in IDLE with `clear`=1 is ignored.
  - Out-of-range latched address (>= MAX_SPRITES): the response still occurs with normal latency, with `oam_data` = all zeros.
- Bank swap:
  - `swap_req`=1 sets `swap_pending`.
  - While `swap_pending`=1 and the FSM is in IDLE with no `oam_read` accepted this cycle, `front_bank` toggles and `swap_pending` clears on the next edge.
  - Multiple `swap_req` pulses before the swap is taken collapse into a single swap.
  - A read in flight always completes from the bank latched at request time.
  - A write in the same cycle as the toggle goes to the pre-toggle back bank.

## Timing
- Reset values: `oam_avail`=0, `oam_data`=0, `front_bank`=0, state IDLE, `swap_pending`=0.
- Read latency is fixed: `oam_read` accepted at edge N gives `oam_avail`=1 in the cycle after edge N+2. The scanner's MEM_REQ state therefore lasts exactly 2 cycles.
- Maximum throughput: one read per 3 cycles.
- Write-to-visible: data written to the back bank at edge N is readable by the scanner after the next completed swap.
- Swap latency with FSM idle and no request:
  - `swap_req` at edge N sets `swap_pending`.
  - `front_bank` flips at edge N+1.
- If `swap_req` coincides with an accepted read, the swap occurs at the first edge at which the FSM is back in IDLE with no new read accepted.
- Reset asserted mid-read: state returns to IDLE asynchronously, `oam_avail` drops immediately, and no response is produced after reset release.

## Test plan
- Write 0x55-pattern entry to back-bank address 3; pulse `swap_req`; read address 3 -> `oam_avail` exactly 2 cycles after the `oam_read` edge, `oam_data` = pattern, `front_bank`=1.
- Read address 3 while changing `oam_addr` to 4 in the following cycle -> response returns entry 3, not entry 4.
- Issue read, then pulse `swap_req` the next cycle -> response comes from the old bank; `front_bank` toggles only after RESP.
- Issue read, then assert `clear` in RAM_WAIT -> no `oam_avail`; a new read 1 cycle later is served normally.
- Read address MAX_SPRITES (e.g. 64) -> `oam_avail` after 2 cycles with `oam_data`=0. Write to address 64 -> no bank entry changes.
- Scanner-in-loop: 64 sprites loaded, row=10, only sprites 5 and 40 in range -> scanner sees exactly two `conf_ack`s in order, and `conf_exists` deasserts after address 64.

Source files
------------

// File: rtl/oam_responder.sv
// oam_responder: double-buffered OAM read port for the sprite scanner.
// Fixed two-cycle read latency; bank swaps wait for an idle read FSM.
`ifndef MAX_SPRITES
`define MAX_SPRITES 64
`endif

package sprite_pkg;
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] tile;
        logic [2:0] palette;
        logic       flip_h;
        logic       flip_v;
    } sprite_conf_t;
endpackage

module oam_responder
    import sprite_pkg::*;
#(
    parameter int MAX_SPRITES = `MAX_SPRITES
) (
    input  logic         clock,
    input  logic         reset_l,
    input  logic         clear,
    input  logic [6:0]   oam_addr,
    input  logic         oam_read,
    output logic         oam_avail,
    output sprite_conf_t oam_data,
    input  logic         wr_en,
    input  logic [6:0]   wr_addr,
    input  sprite_conf_t wr_data,
    input  logic         swap_req,
    output logic         front_bank
);

    localparam int AW = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RAM_WAIT,
        RESP
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    sprite_conf_t r_bank0 [MAX_SPRITES];
    sprite_conf_t r_bank1 [MAX_SPRITES];
    sprite_conf_t r_q0;
    sprite_conf_t r_q1;
    sprite_conf_t r_data;

    logic         r_req_bank;
    logic         r_req_oor;
    logic         r_front;
    logic         r_swap_pending;
    logic         r_avail;

    logic         w_accept;
    logic         w_load;
    logic         w_avail_nxt;
    logic         w_toggle;
    logic         w_rd_in_range;
    logic         w_wr_in_range;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_wr_idx;

    assign w_rd_in_range = int'(oam_addr) < MAX_SPRITES;
    assign w_wr_in_range = int'(wr_addr) < MAX_SPRITES;
    assign w_rd_idx      = oam_addr[AW-1:0];
    assign w_wr_idx      = wr_addr[AW-1:0];

    // Both banks are read at accept; the latched bank picks one later,
    // so a swap can never redirect a read already in flight.
    always_ff @(posedge clock) begin
        if (wr_en && w_wr_in_range) begin
            if (r_front) begin
                r_bank0[w_wr_idx] <= wr_data;
            end else begin
                r_bank1[w_wr_idx] <= wr_data;
            end
        end
        if (w_accept && w_rd_in_range) begin
            r_q0 <= r_bank0[w_rd_idx];
            r_q1 <= r_bank1[w_rd_idx];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_avail_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (oam_read && !clear) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RAM_WAIT;
                end
            end
            RAM_WAIT: begin
                w_load      = !clear;
                w_state_nxt = clear ? IDLE : RESP;
            end
            RESP: begin
                w_avail_nxt = !clear;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_toggle = r_swap_pending && (r_state == IDLE) && !w_accept;

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_state        <= IDLE;
            r_avail        <= 1'b0;
            r_data         <= '0;
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
            r_req_bank     <= 1'b0;
            r_req_oor      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_avail <= w_avail_nxt;
            if (w_accept) begin
                r_req_bank <= r_front;
                r_req_oor  <= !w_rd_in_range;
            end
            if (w_load) begin
                r_data <= r_req_oor ? '0 : (r_req_bank ? r_q1 : r_q0);
            end
            // a pulse arriving on the swap edge folds into that swap
            r_swap_pending <= w_toggle ? 1'b0 : (r_swap_pending | swap_req);
            if (w_toggle) begin
                r_front <= ~r_front;
            end
        end
    end

    assign oam_avail  = r_avail;
    assign oam_data   = r_data;
    assign front_bank = r_front;

endmodule
